// File: rtl/axi_mst_bridge.sv
// AXI4 master bridge: turns a single-outstanding local request/write-data interface
// into AXI4 AR/AW/W transactions and returns R beats / B completions on one response stream.

package axi_mst_bridge_pkg;

  localparam int CFG_SYSBUS_ADDR_BITS  = 32;
  localparam int CFG_SYSBUS_DATA_BITS  = 64;
  localparam int CFG_SYSBUS_DATA_BYTES = CFG_SYSBUS_DATA_BITS / 8;
  localparam int CFG_SYSBUS_ID_BITS    = 5;
  localparam int CFG_SYSBUS_USER_BITS  = 1;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;

  typedef struct packed {
    logic [CFG_SYSBUS_ADDR_BITS-1:0] addr;
    logic [7:0]                      len;
    logic [2:0]                      size;
    logic [1:0]                      burst;
    logic                            lock;
    logic [3:0]                      cache;
    logic [2:0]                      prot;
    logic [3:0]                      region;
    logic [3:0]                      qos;
  } axi4_metadata_type;

  typedef struct packed {
    logic                            aw_valid;
    axi4_metadata_type               aw_bits;
    logic [CFG_SYSBUS_ID_BITS-1:0]   aw_id;
    logic [CFG_SYSBUS_USER_BITS-1:0] aw_user;
    logic                            w_valid;
    logic [CFG_SYSBUS_DATA_BITS-1:0] w_data;
    logic                            w_last;
    logic [CFG_SYSBUS_DATA_BYTES-1:0] w_strb;
    logic [CFG_SYSBUS_USER_BITS-1:0] w_user;
    logic                            b_ready;
    logic                            ar_valid;
    axi4_metadata_type               ar_bits;
    logic [CFG_SYSBUS_ID_BITS-1:0]   ar_id;
    logic [CFG_SYSBUS_USER_BITS-1:0] ar_user;
    logic                            r_ready;
  } axi4_master_out_type;

  typedef struct packed {
    logic                            aw_ready;
    logic                            w_ready;
    logic                            b_valid;
    logic [1:0]                      b_resp;
    logic                            ar_ready;
    logic                            r_valid;
    logic [1:0]                      r_resp;
    logic [CFG_SYSBUS_DATA_BITS-1:0] r_data;
    logic                            r_last;
  } axi4_master_in_type;

  localparam axi4_master_out_type axi4_master_out_none = '0;

endpackage

module axi_mst_bridge
  import axi_mst_bridge_pkg::*;
#(
  parameter logic [CFG_SYSBUS_ID_BITS-1:0] req_id = '0
) (
  input  logic                             i_clk,
  input  logic                             i_nrst,
  input  axi4_master_in_type               i_xmsti,
  output axi4_master_out_type              o_xmsto,
  input  logic                             i_req_valid,
  output logic                             o_req_ready,
  input  logic [CFG_SYSBUS_ADDR_BITS-1:0]  i_req_addr,
  input  logic                             i_req_write,
  input  logic [7:0]                       i_req_len,
  input  logic [2:0]                       i_req_size,
  input  logic                             i_wdata_valid,
  output logic                             o_wdata_ready,
  input  logic [CFG_SYSBUS_DATA_BITS-1:0]  i_wdata,
  input  logic [CFG_SYSBUS_DATA_BYTES-1:0] i_wstrb,
  output logic                             o_resp_valid,
  input  logic                             i_resp_ready,
  output logic                             o_resp_write,
  output logic [CFG_SYSBUS_DATA_BITS-1:0]  o_resp_rdata,
  output logic                             o_resp_last,
  output logic                             o_resp_err
);

  typedef enum logic [2:0] {StIdle, StAr, StR, StAw, StW, StB} state_e;

  state_e                          state_q;
  axi4_master_out_type             xmsto_q;
  logic                            req_ready_q;
  logic                            wdata_ready_q;
  logic                            resp_valid_q;
  logic                            resp_write_q;
  logic [CFG_SYSBUS_DATA_BITS-1:0] resp_rdata_q;
  logic                            resp_last_q;
  logic                            resp_err_q;
  logic [7:0]                      beat_cnt_q;
  axi4_metadata_type               req_meta;
  logic                            unused_resp;

  // Only bit 1 of the response code (SLVERR/DECERR) matters here.
  assign unused_resp = ^{i_xmsti.r_resp[0], i_xmsti.b_resp[0]};

  // Address-phase attributes built from the incoming request; everything else fixed.
  always_comb begin
    req_meta       = '0;
    req_meta.addr  = i_req_addr;
    req_meta.len   = i_req_len;
    req_meta.size  = i_req_size;
    req_meta.burst = AXI_BURST_INCR;
  end

  // Transaction sequencer; every output of the block is a register updated here.
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      state_q       <= StIdle;
      xmsto_q       <= axi4_master_out_none;
      req_ready_q   <= 1'b0;
      wdata_ready_q <= 1'b0;
      resp_valid_q  <= 1'b0;
      resp_write_q  <= 1'b0;
      resp_rdata_q  <= '0;
      resp_last_q   <= 1'b0;
      resp_err_q    <= 1'b0;
      beat_cnt_q    <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (req_ready_q && i_req_valid) begin
            req_ready_q <= 1'b0;
            beat_cnt_q  <= i_req_len;
            if (i_req_write) begin
              xmsto_q.aw_valid <= 1'b1;
              xmsto_q.aw_bits  <= req_meta;
              xmsto_q.aw_id    <= req_id;
              state_q          <= StAw;
            end else begin
              xmsto_q.ar_valid <= 1'b1;
              xmsto_q.ar_bits  <= req_meta;
              xmsto_q.ar_id    <= req_id;
              state_q          <= StAr;
            end
          end else begin
            // Also raises ready on the first clock after reset release.
            req_ready_q <= 1'b1;
          end
        end
        StAr: begin
          if (i_xmsti.ar_ready) begin
            xmsto_q.ar_valid <= 1'b0;
            xmsto_q.r_ready  <= 1'b1;
            state_q          <= StR;
          end
        end
        StR: begin
          // r_ready and resp_valid are never both high, so the branches never collide.
          if (xmsto_q.r_ready && i_xmsti.r_valid) begin
            xmsto_q.r_ready <= 1'b0;
            resp_valid_q    <= 1'b1;
            resp_write_q    <= 1'b0;
            resp_rdata_q    <= i_xmsti.r_data;
            resp_last_q     <= i_xmsti.r_last;
            resp_err_q      <= i_xmsti.r_resp[1];
          end else if (resp_valid_q && i_resp_ready) begin
            resp_valid_q <= 1'b0;
            if (resp_last_q) begin
              req_ready_q <= 1'b1;
              state_q     <= StIdle;
            end else begin
              xmsto_q.r_ready <= 1'b1;
            end
          end
        end
        StAw: begin
          if (i_xmsti.aw_ready) begin
            xmsto_q.aw_valid <= 1'b0;
            wdata_ready_q    <= 1'b1;
            state_q          <= StW;
          end
        end
        StW: begin
          if (wdata_ready_q && i_wdata_valid) begin
            wdata_ready_q  <= 1'b0;
            xmsto_q.w_valid <= 1'b1;
            xmsto_q.w_data  <= i_wdata;
            xmsto_q.w_strb  <= i_wstrb;
            xmsto_q.w_last  <= (beat_cnt_q == 8'd0);
          end else if (xmsto_q.w_valid && i_xmsti.w_ready) begin
            xmsto_q.w_valid <= 1'b0;
            xmsto_q.w_last  <= 1'b0;
            if (xmsto_q.w_last) begin
              xmsto_q.b_ready <= 1'b1;
              state_q         <= StB;
            end else begin
              beat_cnt_q    <= beat_cnt_q - 8'd1;
              wdata_ready_q <= 1'b1;
            end
          end
        end
        StB: begin
          if (xmsto_q.b_ready && i_xmsti.b_valid) begin
            xmsto_q.b_ready <= 1'b0;
            resp_valid_q    <= 1'b1;
            resp_write_q    <= 1'b1;
            resp_last_q     <= 1'b1;
            resp_err_q      <= i_xmsti.b_resp[1];
            resp_rdata_q    <= '0;
          end else if (resp_valid_q && i_resp_ready) begin
            resp_valid_q <= 1'b0;
            req_ready_q  <= 1'b1;
            state_q      <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign o_xmsto       = xmsto_q;
  assign o_req_ready   = req_ready_q;
  assign o_wdata_ready = wdata_ready_q;
  assign o_resp_valid  = resp_valid_q;
  assign o_resp_write  = resp_write_q;
  assign o_resp_rdata  = resp_rdata_q;
  assign o_resp_last   = resp_last_q;
  assign o_resp_err    = resp_err_q;

endmodule

// File: tb/tb_axi_mst_bridge.sv
// Bench for axi_mst_bridge: directed scenarios plus randomized transactions, each checked
// against expectations built from the transaction description (beats in, responses out).

module tb_axi_mst_bridge;
  import axi_mst_bridge_pkg::*;

  localparam logic [CFG_SYSBUS_ID_BITS-1:0] ReqId = 5'h0B;

  typedef struct packed {
    logic        w;
    logic [63:0] d;
    logic        l;
    logic        e;
  } resp_t;

  logic                clk;
  logic                nrst;
  axi4_master_in_type  xin;
  axi4_master_out_type xout;
  logic                req_valid, req_ready, req_write;
  logic [31:0]         req_addr;
  logic [7:0]          req_len;
  logic [2:0]          req_size;
  logic                wdata_valid, wdata_ready;
  logic [63:0]         wdata;
  logic [7:0]          wstrb;
  logic                resp_valid, resp_ready, resp_write, resp_last, resp_err;
  logic [63:0]         resp_rdata;

  int total = 0;
  int bad   = 0;
  int viol  = 0;
  int slot  = 0;

  axi_mst_bridge #(.req_id(ReqId)) dut (
    .i_clk         (clk),
    .i_nrst        (nrst),
    .i_xmsti       (xin),
    .o_xmsto       (xout),
    .i_req_valid   (req_valid),
    .o_req_ready   (req_ready),
    .i_req_addr    (req_addr),
    .i_req_write   (req_write),
    .i_req_len     (req_len),
    .i_req_size    (req_size),
    .i_wdata_valid (wdata_valid),
    .o_wdata_ready (wdata_ready),
    .i_wdata       (wdata),
    .i_wstrb       (wstrb),
    .o_resp_valid  (resp_valid),
    .i_resp_ready  (resp_ready),
    .o_resp_write  (resp_write),
    .o_resp_rdata  (resp_rdata),
    .o_resp_last   (resp_last),
    .o_resp_err    (resp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    slot++;
  endtask

  function automatic bit roll(input int pct);
    return $urandom_range(99, 0) < pct;
  endfunction

  // One complete transaction with the bench acting as AXI slave, data source and response sink.
  task automatic run_txn(
    input bit wr, input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size,
    input int rdy_pct, input int resp_mode, input int wdelay, input int resp_sel,
    input bit use_d0, input logic [63:0] d0, input logic [63:0] dstep,
    input bit hold_nxt, input bit nwr, input logic [31:0] naddr, input logic [7:0] nlen,
    input logic [2:0] nsize,
    output int lat_req, output int lat_resp, output int lat_rdy);
    logic [63:0] rd_q[$];
    logic [1:0]  rr_q[$];
    logic [63:0] ew_d[$];
    logic [7:0]  ew_s[$];
    logic [63:0] sd[$];
    logic [7:0]  ss[$];
    resp_t       exp_q[$];
    resp_t       er;
    axi4_metadata_type em;
    logic [63:0] d;
    logic [7:0]  s;
    logic [1:0]  r;
    logic [1:0]  bresp;
    bit req_done, ar_done, aw_done, b_pend, fin, after_req;
    bit req_f, r_f, b_f, wd_f;
    int src_idx, wv_cnt, n_ar, n_aw, first_resp, start;
    {req_done, ar_done, aw_done, b_pend, fin, after_req} = '0;
    {req_f, r_f, b_f, wd_f} = '0;
    src_idx = 0; wv_cnt = 0; n_ar = 0; n_aw = 0; first_resp = -1; lat_req = -1;
    start = slot;
    em = '0; em.addr = addr; em.len = len; em.size = size; em.burst = 2'b01;
    for (int i = 0; i <= int'(len); i++) begin
      d = use_d0 ? d0 + dstep * i : {$urandom, $urandom};
      s = use_d0 ? 8'hFF : 8'($urandom);
      r = (resp_sel < 0) ? 2'($urandom_range(3, 0)) : 2'(resp_sel);
      if (wr) begin
        ew_d.push_back(d); ew_s.push_back(s);
      end else begin
        rd_q.push_back(d); rr_q.push_back(r);
        exp_q.push_back('{w: 1'b0, d: d, l: (i == int'(len)), e: r[1]});
      end
    end
    sd = ew_d; ss = ew_s;
    bresp = (resp_sel < 0) ? 2'($urandom_range(3, 0)) : 2'(resp_sel);
    if (wr) exp_q.push_back('{w: 1'b1, d: 64'h0, l: 1'b1, e: bresp[1]});
    req_valid = 1'b1; req_write = wr; req_addr = addr; req_len = len; req_size = size;
    for (int c = 0; c < 4000 && !fin; c++) begin
      if (req_f) begin
        if (hold_nxt) begin
          req_write = nwr; req_addr = naddr; req_len = nlen; req_size = nsize;
        end else begin
          req_valid = 1'b0;
        end
      end
      if (r_f) xin.r_valid = 1'b0;
      if (b_f) xin.b_valid = 1'b0;
      if (wd_f) wdata_valid = 1'b0;
      {req_f, r_f, b_f, wd_f} = '0;
      if (after_req) begin
        check(wr ? "aw_valid after req" : "ar_valid after req",
              wr ? xout.aw_valid : xout.ar_valid, 1);
        after_req = 1'b0;
      end
      if (resp_valid && first_resp < 0) first_resp = slot - start;
      if (xout.r_ready && resp_valid) viol++;
      if (xout.w_valid && !aw_done) viol++;
      if (req_done && req_ready) viol++;
      xin.ar_ready = roll(rdy_pct);
      xin.aw_ready = roll(rdy_pct);
      if (xout.w_valid) begin
        wv_cnt++;
        xin.w_ready = (wv_cnt > wdelay) && roll(rdy_pct);
      end else begin
        wv_cnt = 0;
        xin.w_ready = 1'b0;
      end
      if (ar_done && rd_q.size() > 0) begin
        if (!xin.r_valid) xin.r_valid = roll(rdy_pct);
        xin.r_data = rd_q[0];
        xin.r_resp = rr_q[0];
        xin.r_last = (rd_q.size() == 1);
      end
      if (b_pend) begin
        if (!xin.b_valid) xin.b_valid = roll(rdy_pct);
        xin.b_resp = bresp;
      end
      if (wr) begin
        if (src_idx <= int'(len)) begin
          if (!wdata_valid) wdata_valid = roll(rdy_pct);
          wdata = sd[src_idx];
          wstrb = ss[src_idx];
        end else begin
          // Surplus beats offered; the bridge must ignore them.
          wdata_valid = 1'b1; wdata = '1; wstrb = '1;
        end
      end
      case (resp_mode)
        0:       resp_ready = roll(50);
        1:       resp_ready = !resp_ready;
        default: resp_ready = 1'b1;
      endcase
      // Handshakes that complete at the coming edge.
      if (req_valid && req_ready && !req_done) begin
        req_done = 1'b1; req_f = 1'b1; after_req = 1'b1; lat_req = slot - start;
      end
      if (xout.ar_valid && xin.ar_ready) begin
        n_ar++; ar_done = 1'b1;
        check("ar bits", xout.ar_bits, em);
        check("ar id", xout.ar_id, ReqId);
      end
      if (xout.aw_valid && xin.aw_ready) begin
        n_aw++; aw_done = 1'b1;
        check("aw bits", xout.aw_bits, em);
        check("aw id", xout.aw_id, ReqId);
      end
      if (xout.r_ready && xin.r_valid) begin
        void'(rd_q.pop_front()); void'(rr_q.pop_front()); r_f = 1'b1;
      end
      if (xout.w_valid && xin.w_ready) begin
        if (ew_d.size() == 0) viol++;
        else begin
          check("w beat", {xout.w_data, xout.w_strb, xout.w_last},
                {ew_d[0], ew_s[0], 1'(ew_d.size() == 1)});
          void'(ew_d.pop_front()); void'(ew_s.pop_front());
          if (ew_d.size() == 0) b_pend = 1'b1;
        end
      end
      if (wdata_valid && wdata_ready) begin
        if (!wr || src_idx > int'(len)) viol++;
        src_idx++; wd_f = 1'b1;
      end
      if (xin.b_valid && xout.b_ready) begin
        b_pend = 1'b0; b_f = 1'b1;
      end
      if (resp_valid && resp_ready) begin
        if (exp_q.size() == 0) viol++;
        else begin
          er = exp_q.pop_front();
          check("resp", {resp_write, resp_rdata, resp_last, resp_err}, {er.w, er.d, er.l, er.e});
          if (exp_q.size() == 0) fin = 1'b1;
        end
      end
      tick();
    end
    check("txn complete", fin, 1);
    check("req_ready after last resp", req_ready, 1);
    check("ar count", n_ar, !wr);
    check("aw count", n_aw, wr);
    if (wr) check("write beats taken", src_idx, int'(len) + 1);
    lat_resp = first_resp - lat_req;
    lat_rdy  = (slot - start) - lat_req;
    xin.r_valid = 1'b0; xin.b_valid = 1'b0; wdata_valid = 1'b0;
  endtask

  initial begin
    int lr, lp, ly;
    nrst = 1'b0; xin = '0; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_len = '0;
    req_size = '0; wdata_valid = 1'b0; wdata = '0; wstrb = '0; resp_ready = 1'b0;
    #1;
    check("reset xmsto", xout === axi4_master_out_none, 1);
    check("reset flags", {req_ready, wdata_ready, resp_valid, resp_write, resp_last, resp_err}, 0);
    repeat (2) @(posedge clk);
    #3 nrst = 1'b1;
    tick();
    check("req_ready out of reset", req_ready, 1);

    // Minimum-latency single-beat read.
    run_txn(0, 32'h8000_1000, 8'd0, 3'd3, 100, 2, 0, 0, 1, 64'h1122_3344_5566_7788, 64'd0,
            0, 0, 0, 0, 0, lr, lp, ly);
    check("min read resp latency", lp, 3);
    check("min read req_ready latency", ly, 4);

    // Four-beat read, toggling response ready, next request (a write) held pending.
    run_txn(0, 32'h8000_2000, 8'd3, 3'd3, 100, 1, 0, 0, 1, 64'd0, 64'd1,
            1, 1, 32'h8000_3000, 8'd1, 3'd3, lr, lp, ly);
    // Held write: two beats, w_ready delayed three cycles.
    run_txn(1, 32'h8000_3000, 8'd1, 3'd3, 100, 2, 3, 0, 1, 64'h0000_AAAA, 64'h0000_1111,
            0, 0, 0, 0, 0, lr, lp, ly);
    check("held request accepted at once", lr, 0);

    // Error responses.
    run_txn(1, 32'h8000_4000, 8'd2, 3'd3, 70, 0, 1, 2, 0, 64'd0, 64'd0,
            0, 0, 0, 0, 0, lr, lp, ly);
    run_txn(0, 32'h8000_5000, 8'd1, 3'd3, 70, 0, 0, 3, 0, 64'd0, 64'd0,
            0, 0, 0, 0, 0, lr, lp, ly);

    // Reset in the middle of a write burst.
    req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h8000_6000; req_len = 8'd3;
    req_size = 3'd3; xin.aw_ready = 1'b1; xin.w_ready = 1'b0;
    wdata_valid = 1'b1; wdata = 64'hDEAD; wstrb = '1;
    tick();
    req_valid = 1'b0;
    tick();
    tick();
    check("w_valid before reset", xout.w_valid, 1);
    #2 nrst = 1'b0;
    #1;
    check("mid-burst reset xmsto", xout === axi4_master_out_none, 1);
    check("mid-burst reset flags",
          {req_ready, wdata_ready, resp_valid, resp_write, resp_last, resp_err}, 0);
    check("mid-burst reset rdata", resp_rdata, 0);
    xin = '0; wdata_valid = 1'b0;
    #2 nrst = 1'b1;
    tick();
    check("req_ready after reset release", req_ready, 1);
    check("no response after abandon", resp_valid, 0);
    run_txn(0, 32'h8000_7000, 8'd2, 3'd2, 100, 2, 0, 0, 0, 64'd0, 64'd0,
            0, 0, 0, 0, 0, lr, lp, ly);

    // Randomized transactions.
    for (int t = 0; t < 24; t++) begin
      run_txn(1'($urandom_range(1, 0)), $urandom, 8'($urandom_range(7, 0)),
              3'($urandom_range(3, 0)), $urandom_range(100, 40), $urandom_range(2, 0),
              $urandom_range(2, 0), -1, 0, 64'd0, 64'd0, 0, 0, 0, 0, 0, lr, lp, ly);
    end

    check("protocol violations", viol, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/axi_mst_bridge.md
# axi_mst_bridge

Converts a simple single-outstanding request interface into AXI4 master transactions on the system bus. It is the initiator-side counterpart of the slave adapter: a local engine (DMA, rasterizer fetch unit) issues address/length/write requests and streams write data. The block drives AR/AW/W, collects R/B, and returns read beats and write completions on one response stream. It sits between such an engine and an interconnect master port.

## Interface
- req_id, default 0: constant value driven on ar_id/aw_id, CFG_SYSBUS_ID_BITS wide.
- i_clk  in  1  system clock.
- i_nrst  in  1  reset, asynchronous, active-low.
- i_xmsti  in  axi4_master_in_type  AXI master inputs: ar_ready, aw_ready, w_ready, r_valid/r_data/r_resp/r_last, b_valid/b_resp.
- o_xmsto  out  axi4_master_out_type  AXI master outputs: ar/aw valid+bits, w valid/data/strb/last, r_ready, b_ready.
- i_req_valid  in  1  request valid.
- o_req_ready  out  1  request accepted when valid&ready.
- i_req_addr  in  CFG_SYSBUS_ADDR_BITS  byte address.
- i_req_write  in  1  1=write, 0=read.
- i_req_len  in  8  AXI len (beats-1).
- i_req_size  in  3  AXI size code.
- i_wdata_valid  in  1  write beat valid.
- o_wdata_ready  out  1  write beat accepted.
- i_wdata  in  CFG_SYSBUS_DATA_BITS  write data.
- i_wstrb  in  CFG_SYSBUS_DATA_BYTES  byte strobes.
- o_resp_valid  out  1  response valid.
- i_resp_ready  in  1  response accepted.
- o_resp_write  out  1  response belongs to a write.
- o_resp_rdata  out  CFG_SYSBUS_DATA_BITS  read data, 0 for writes.
- o_resp_last  out  1  last beat of transaction.
- o_resp_err  out  1  r_resp/b_resp bit 1 set (SLVERR/DECERR).

## Operation
- All outputs come from registers. Reset (async, i_nrst=0): every output 0, o_xmsto = axi4_master_out_none, state Idle, beat counter 0.
- AXI attributes fixed: burst INCR, lock/cache/prot/qos/region 0, user 0, id = req_id. addr/len/size copied from the accepted request. 4 KB boundary crossing is the requester's responsibility; not checked.
- States: Idle, Ar, R, Aw, W, B.
- Idle: o_req_ready=1. On valid&ready: latch addr/len/size, beat counter = len, o_req_ready<=0; read -> Ar with ar_valid<=1; write -> Aw with aw_valid<=1.
- Ar: hold ar_valid/bits stable until ar_ready; then ar_valid<=0, r_ready<=1, -> R.
- R: one-entry response buffer. On r_valid&r_ready: capture r_data, r_last, r_resp[1] into o_resp_*, o_resp_valid<=1, o_resp_write<=0, r_ready<=0. On o_resp_valid&i_resp_ready: o_resp_valid<=0; if captured beat was last -> Idle (o_req_ready<=1), else r_ready<=1. o_resp_last follows r_last from the bus, not the counter.
- Aw: hold aw_valid until aw_ready; then aw_valid<=0, o_wdata_ready<=1, -> W. No W beat is driven before the AW handshake.
- W: one-entry data buffer. On i_wdata_valid&o_wdata_ready: load w_data/w_strb, w_last=(counter==0), w_valid<=1, o_wdata_ready<=0. On w_valid&w_ready: w_valid<=0, w_last<=0; if beat was last -> b_ready<=1, -> B; else counter-1, o_wdata_ready<=1. Exactly len+1 beats are taken; further i_wdata_valid is ignored until the next write.
- B: on b_valid&b_ready: b_ready<=0, o_resp_valid<=1, o_resp_write<=1, o_resp_last<=1, o_resp_err=b_resp[1], o_resp_rdata=0. On response handshake -> Idle, o_req_ready<=1.
- r_id/b_id are not checked; single outstanding transaction.

## Timing
- Request handshake at cycle N -> ar_valid/aw_valid high at N+1.
- Read: R handshake at M -> o_resp_valid at M+1; with i_resp_ready=1 next r_ready at M+2. Throughput 1 beat / 2 cycles.
- Write: AW handshake at M -> o_wdata_ready at M+1; beat accepted at K -> w_valid at K+1. Throughput 1 beat / 2 cycles with w_ready=1.
- Last response handshake at L -> o_req_ready at L+1. Min single-beat read, all ready=1: req N, ar_valid N+1, r_ready N+2, resp N+3, req_ready N+4.
- A request presented while not Idle waits (o_req_ready=0); no drop.
- Reset mid-burst: outputs drop to 0 asynchronously; transaction abandoned, no response produced.

## Test plan
- Single read addr 0x80001000 len 0 size 3, r_data 0x1122334455667788 resp OKAY -> ar_bits.addr=0x80001000, len=0, burst INCR; one response rdata=0x1122334455667788, last=1, err=0, write=0.
- Read len 3, slave R data 0..3, i_resp_ready toggled every cycle -> 4 responses in order, last only on 4th, r_ready never high while o_resp_valid=1.
- Write len 1, two beats 0xAAAA/0xBBBB strb 0xFF, w_ready delayed 3 cycles -> w_valid not before AW handshake, w_last only on 2nd beat, one response write=1 last=1 err=0.
- Write with b_resp=SLVERR (2'b10) -> o_resp_err=1; read beat with r_resp=DECERR -> that beat err=1.
- New request held valid during a read burst -> o_req_ready=0 until last response accepted, then accepted next cycle, ar/aw_valid one cycle later.
- Assert i_nrst=0 mid write burst -> all outputs 0 same cycle; after release o_req_ready=1 next clock, new read completes normally.
